// File: rtl/rs_chien_forney_corrector.sv
// Reed-Solomon GF(2^8) (poly 0x11D) Chien search and Forney corrector for shortened codes.
// Scales sigma/omega to the code length, then streams corrected delay-buffer symbols downstream.
module rs_chien_forney_corrector #(
    parameter int NPAR = 16,
    parameter int AW   = 5,
    parameter int FCR  = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          coef_wr,
    input  logic          coef_sel,
    input  logic [AW-1:0] coef_addr,
    input  logic [7:0]    coef_data,
    input  logic [AW-1:0] locator_degree,
    input  logic [7:0]    code_len,
    input  logic          start,
    output logic          busy,
    output logic          buf_rden,
    output logic [7:0]    buf_rdaddr,
    input  logic [7:0]    buf_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_err,
    output logic          out_last,
    output logic          done,
    output logic          decoder_fail,
    output logic [AW-1:0] error_count
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_exp(input logic [7:0] e);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h01;
        b = 8'h02;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) p = gf_mul(p, b);
            b = gf_mul(b, b);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_log(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] l;
        p = 8'h01;
        l = 8'h00;
        for (int i = 0; i < 255; i++) begin
            if (p == x) l = 8'(i);
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
        end
        return l;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        return gf_exp(8'd255 - gf_log(x));
    endfunction

    localparam logic [7:0] ALPHA_FCR = gf_exp(8'(FCR % 255));
    localparam logic [7:0] MIN_LEN   = 8'(2 * NPAR + 1);

    typedef enum logic [1:0] {IDLE, PRECOMP, RUN} state_t;

    state_t        state;
    logic [7:0]    sig [NPAR+1];
    logic [7:0]    omg [NPAR+1];
    logic [7:0]    n_reg, s_reg, pw, xb, addr;
    logic [AW-1:0] pc;
    logic          v0, last0;
    logic [7:0]    sig_s0, odd_s0, omg_s0, xb_s0;
    logic          out_root, out_bad, fail_sticky;

    logic          advance, issue, accept, is_root, odd_zero, fix;
    logic [7:0]    sig_eval, odd_eval, omg_eval, err_val;
    logic [AW-1:0] cnt_next;

    // The read enable must drop in the very cycle the output stalls, so it is decoded, not registered.
    assign advance    = !out_valid || out_ready;
    assign issue      = (state == RUN) && (addr != n_reg) && advance;
    assign buf_rden   = issue;
    assign buf_rdaddr = addr;
    assign accept     = out_valid && out_ready;

    assign is_root  = (sig_s0 == 8'h00);
    assign odd_zero = (odd_s0 == 8'h00);
    assign fix      = is_root && !odd_zero;
    assign err_val  = gf_mul(gf_mul(xb_s0, omg_s0), gf_inv(odd_s0));
    assign cnt_next = (accept && out_root && error_count != '1) ? error_count + AW'(1) : error_count;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sig_eval = 8'h00;
        odd_eval = 8'h00;
        omg_eval = 8'h00;
        for (int k = 0; k <= NPAR; k++) begin
            sig_eval = sig_eval ^ sig[k];
            omg_eval = omg_eval ^ omg[k];
            if (k % 2 == 1) odd_eval = odd_eval ^ sig[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            decoder_fail <= 1'b0;
            error_count  <= '0;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            out_err      <= 1'b0;
            out_last     <= 1'b0;
            out_root     <= 1'b0;
            out_bad      <= 1'b0;
            fail_sticky  <= 1'b0;
            n_reg        <= 8'h00;
            s_reg        <= 8'h00;
            pw           <= 8'h00;
            xb           <= 8'h00;
            addr         <= 8'h00;
            pc           <= '0;
            v0           <= 1'b0;
            last0        <= 1'b0;
            sig_s0       <= 8'h00;
            odd_s0       <= 8'h00;
            omg_s0       <= 8'h00;
            xb_s0        <= 8'h00;
            // NOTE: the coefficient banks are reset because an unloaded sigma/omega must read as zero.
            for (int k = 0; k <= NPAR; k++) begin
                sig[k] <= 8'h00;
                omg[k] <= 8'h00;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coef_wr) begin
                        for (int k = 0; k <= NPAR; k++) begin
                            if (coef_addr == AW'(k)) begin
                                if (coef_sel) omg[k] <= coef_data;
                                else          sig[k] <= coef_data;
                            end
                        end
                    end
                    if (start) begin
                        error_count  <= '0;
                        decoder_fail <= 1'b0;
                        fail_sticky  <= 1'b0;
                        if (code_len >= MIN_LEN) begin
                            n_reg <= code_len;
                            s_reg <= gf_exp(8'(256 - int'(code_len)));
                            xb    <= gf_exp(8'(((256 - int'(code_len)) * FCR) % 255));
                            pw    <= 8'h01;
                            pc    <= '0;
                            addr  <= 8'h00;
                            busy  <= 1'b1;
                            state <= PRECOMP;
                        end else begin
                            done         <= 1'b1;
                            decoder_fail <= 1'b1;
                            for (int k = 0; k <= NPAR; k++) begin
                                sig[k] <= 8'h00;
                                omg[k] <= 8'h00;
                            end
                        end
                    end
                end

                PRECOMP: begin
                    for (int k = 0; k <= NPAR; k++) begin
                        if (pc == AW'(k)) begin
                            sig[k] <= gf_mul(sig[k], pw);
                            omg[k] <= gf_mul(omg[k], pw);
                        end
                    end
                    pw <= gf_mul(pw, s_reg);
                    pc <= pc + AW'(1);
                    if (pc == AW'(NPAR)) state <= RUN;
                end

                RUN: begin
                    if (advance) begin
                        out_valid <= v0;
                        if (v0) begin
                            out_data <= fix ? (buf_q ^ err_val) : buf_q;
                            out_err  <= fix;
                            out_root <= is_root;
                            out_bad  <= is_root && odd_zero;
                            out_last <= last0;
                        end
                        v0 <= issue;
                        if (issue) begin
                            addr   <= addr + 8'd1;
                            last0  <= (addr == n_reg - 8'd1);
                            sig_s0 <= sig_eval;
                            odd_s0 <= odd_eval;
                            omg_s0 <= omg_eval;
                            xb_s0  <= xb;
                            xb     <= gf_mul(xb, ALPHA_FCR);
                            for (int k = 0; k <= NPAR; k++) begin
                                sig[k] <= gf_mul(sig[k], gf_exp(8'(k)));
                                omg[k] <= gf_mul(omg[k], gf_exp(8'(k)));
                            end
                        end
                    end
                    if (accept) begin
                        error_count <= cnt_next;
                        if (out_bad) fail_sticky <= 1'b1;
                        if (out_last) begin
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            decoder_fail <= fail_sticky || out_bad || (cnt_next != locator_degree);
                            out_valid    <= 1'b0;
                            out_last     <= 1'b0;
                            v0           <= 1'b0;
                            state        <= IDLE;
                            for (int k = 0; k <= NPAR; k++) begin
                                sig[k] <= 8'h00;
                                omg[k] <= 8'h00;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_chien_forney_corrector.sv
// Scoreboard bench for rs_chien_forney_corrector: directed error patterns, a delay-buffer model
// and an independent sigma/omega builder derived from the chosen error positions and values.
module tb_rs_chien_forney_corrector;

    localparam int NPAR = 16;
    localparam int AW   = 5;
    localparam int FCR  = 0;

    logic          clock;
    logic          reset;
    logic          coef_wr;
    logic          coef_sel;
    logic [AW-1:0] coef_addr;
    logic [7:0]    coef_data;
    logic [AW-1:0] locator_degree;
    logic [7:0]    code_len;
    logic          start;
    logic          busy;
    logic          buf_rden;
    logic [7:0]    buf_rdaddr;
    logic [7:0]    buf_q;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_err;
    logic          out_last;
    logic          done;
    logic          decoder_fail;
    logic [AW-1:0] error_count;

    rs_chien_forney_corrector #(.NPAR(NPAR), .AW(AW), .FCR(FCR)) dut (
        .clock(clock), .reset(reset),
        .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_addr(coef_addr), .coef_data(coef_data),
        .locator_degree(locator_degree), .code_len(code_len), .start(start), .busy(busy),
        .buf_rden(buf_rden), .buf_rdaddr(buf_rdaddr), .buf_q(buf_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .out_last(out_last), .done(done), .decoder_fail(decoder_fail), .error_count(error_count)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         beats    = 0;
    int         done_cnt = 0;
    int         last_acc_cyc = -1;
    int         first_rd = -1;
    int         first_ov = -1;
    bit         bp_en    = 1'b0;

    int         nr;
    int         r_addr [10];
    int         r_deg  [10];
    logic [7:0] r_val  [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_alpha(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < e % 255; i++) p = tb_mul(p, 8'h02);
        return p;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // External delay buffer: registered read, output holds while rden is low.
    initial forever begin
        @(posedge clock);
        if (buf_rden) buf_q <= mem[buf_rdaddr];
    end

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        beat_t e;
        bit    prev_stall;
        logic [7:0] prev_addr;
        prev_stall = 1'b0;
        prev_addr  = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (buf_rden && first_rd < 0) first_rd = cyc;
                if (out_valid && first_ov < 0) first_ov = cyc;
                if (prev_stall) check("stall_addr_frozen", buf_rdaddr, prev_addr);
                if (out_valid && !out_ready) check("stall_rden_low", buf_rden, 1'b0);
                prev_stall = out_valid && !out_ready;
                prev_addr  = buf_rdaddr;
                if (out_valid && out_ready) begin
                    check("beat_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("data[%0d]", beats), out_data, e.data);
                        check($sformatf("err[%0d]", beats), out_err, e.err);
                        check($sformatf("last[%0d]", beats), out_last, e.last);
                    end
                    beats++;
                    if (out_last) last_acc_cyc = cyc;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic clear_roots();
        nr = 0;
    endtask

    task automatic add_err(input int a, input logic [7:0] v);
        r_addr[nr] = a;
        r_val[nr]  = v;
        r_deg[nr]  = 0;
        nr++;
    endtask

    task automatic add_extra_root(input int deg);
        r_addr[nr] = -1;
        r_val[nr]  = 8'h00;
        r_deg[nr]  = deg;
        nr++;
    endtask

    task automatic write_coef(input logic sel, input int k, input logic [7:0] v);
        @(posedge clock);
        #1;
        coef_wr   = 1'b1;
        coef_sel  = sel;
        coef_addr = AW'(k);
        coef_data = v;
    endtask

    // sigma = prod(1 + X_i x); omega = sum_j e_j X_j^FCR prod_{i!=j}(1 + X_i x).
    task automatic load_model();
        logic [7:0] lam [NPAR+1];
        logic [7:0] om  [NPAR+1];
        logic [7:0] p   [NPAR+1];
        logic [7:0] x;
        for (int k = 0; k <= NPAR; k++) begin
            lam[k] = 8'h00;
            om[k]  = 8'h00;
        end
        lam[0] = 8'h01;
        for (int i = 0; i < nr; i++) begin
            x = tb_alpha(r_deg[i]);
            for (int k = NPAR; k >= 1; k--) lam[k] = lam[k] ^ tb_mul(lam[k-1], x);
        end
        for (int j = 0; j < nr; j++) begin
            if (r_val[j] != 8'h00) begin
                for (int k = 0; k <= NPAR; k++) p[k] = 8'h00;
                p[0] = tb_mul(r_val[j], tb_alpha(r_deg[j] * FCR));
                for (int i = 0; i < nr; i++) begin
                    if (i != j) begin
                        x = tb_alpha(r_deg[i]);
                        for (int k = NPAR; k >= 1; k--) p[k] = p[k] ^ tb_mul(p[k-1], x);
                    end
                end
                for (int k = 0; k <= NPAR; k++) om[k] = om[k] ^ p[k];
            end
        end
        for (int k = 0; k <= NPAR; k++) begin
            write_coef(1'b0, k, lam[k]);
            write_coef(1'b1, k, om[k]);
        end
        @(posedge clock);
        #1;
        coef_wr = 1'b0;
    endtask

    task automatic prepare(input int n);
        beat_t b;
        for (int i = 0; i < nr; i++) if (r_addr[i] >= 0) r_deg[i] = n - 1 - r_addr[i];
        exp_q.delete();
        for (int a = 0; a < n; a++) begin
            mem[a] = 8'($urandom);
            b.data = mem[a];
            b.err  = 1'b0;
            b.last = (a == n - 1);
            for (int i = 0; i < nr; i++) begin
                if (r_addr[i] == a) begin
                    b.data = b.data ^ r_val[i];
                    b.err  = 1'b1;
                end
            end
            exp_q.push_back(b);
        end
        load_model();
        beats = 0;
    endtask

    task automatic fire(input int n, input int deg);
        @(posedge clock);
        #1;
        code_len       = 8'(n);
        locator_degree = AW'(deg);
        start          = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input int n, input int deg, input bit bp,
                            input bit poke, input int exp_cnt, input bit exp_fail);
        bit got;
        int my_done;
        prepare(n);
        bp_en = bp;
        fire(n, deg);
        @(negedge clock);
        check({tag, "_busy_after_start"}, busy, 1'b1);
        got     = 1'b0;
        my_done = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clock);
            #1;
            coef_wr = 1'b0;
            start   = 1'b0;
            if (poke && i == 40) begin
                coef_wr   = 1'b1;
                coef_sel  = 1'b0;
                coef_addr = '0;
                coef_data = 8'h00;
                start     = 1'b1;
                code_len  = 8'd100;
            end
            @(negedge clock);
            if (done) begin
                got     = 1'b1;
                my_done = cyc;
            end
        end
        check({tag, "_done_seen"}, got, 1'b1);
        check({tag, "_last_to_done"}, my_done - last_acc_cyc, 1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_error_count"}, error_count, exp_cnt);
        check({tag, "_decoder_fail"}, decoder_fail, exp_fail);
        check({tag, "_beats"}, beats, n);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_fail_held"}, decoder_fail, exp_fail);
        bp_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saved_done;
        reset          = 1'b0;
        coef_wr        = 1'b0;
        coef_sel       = 1'b0;
        coef_addr      = '0;
        coef_data      = 8'h00;
        locator_degree = '0;
        code_len       = 8'd255;
        start          = 1'b0;
        buf_q          = 8'h00;
        out_ready      = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_rden", buf_rden, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_fail", decoder_fail, 1'b0);
        check("reset_error_count", error_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        clear_roots();
        run_case("clean255", 255, 0, 1'b0, 1'b0, 0, 1'b0);
        check("first_valid_latency", first_ov - first_rd, 2);

        clear_roots();
        add_err(10, 8'h5A);
        run_case("single", 255, 1, 1'b0, 1'b0, 1, 1'b0);
        run_case("single_bp", 255, 1, 1'b1, 1'b0, 1, 1'b0);

        clear_roots();
        add_err(0, 8'h01);  add_err(5, 8'hFF);  add_err(17, 8'h3C); add_err(23, 8'h80);
        add_err(31, 8'h5A); add_err(40, 8'hA7); add_err(58, 8'h11); add_err(63, 8'hE2);
        run_case("short64_poke", 64, 8, 1'b0, 1'b1, 8, 1'b0);

        clear_roots();
        add_err(7, 8'h33);
        add_err(50, 8'h9C);
        add_extra_root(100);
        run_case("deg_mismatch", 64, 3, 1'b1, 1'b0, 2, 1'b1);

        clear_roots();
        add_err(32, 8'hC3);
        run_case("min_len33", 33, 1, 1'b0, 1'b0, 1, 1'b0);

        @(posedge clock);
        #1;
        code_len = 8'd32;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("illegal_done", done, 1'b1);
        check("illegal_fail", decoder_fail, 1'b1);
        check("illegal_busy", busy, 1'b0);
        @(negedge clock);
        check("illegal_done_pulse", done, 1'b0);
        check("illegal_no_output", out_valid, 1'b0);

        clear_roots();
        add_err(10, 8'h5A);
        prepare(255);
        fire(255, 1);
        for (int i = 0; i < 1000 && beats < 50; i++) @(negedge clock);
        check("abort_progress", 32'(beats >= 50), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_rden", buf_rden, 1'b0);
        exp_q.delete();
        saved_done = done_cnt;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_done", done_cnt, saved_done);
        run_case("after_abort", 255, 1, 1'b0, 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_chien_forney_corrector.md
Name: rs_chien_forney_corrector

Overview:
- Parametrised successor to the fixed 16-parity Chien/Forney stage of the Reed-Solomon decoder over GF(2^8), primitive polynomial 0x11D.
- Accepts errata locator sigma(x) and magnitude omega(x) coefficients, then runs Chien search and Forney evaluation over a runtime-selectable shortened code length.
- Reads received symbols from the external delay buffer and streams corrected symbols downstream with valid/ready backpressure.
- Flags decoder failure.

Parameters:
NPAR, 16, number of parity symbols; max locator degree = NPAR
AW, 5, coefficient address width; 2^AW > NPAR
FCR, 0, first consecutive root exponent (generator roots alpha^FCR..)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low
coef_wr  in  1  coefficient write strobe
coef_sel  in  1  0 = sigma, 1 = omega
coef_addr  in  AW  coefficient index 0..NPAR
coef_data  in  8  coefficient value
locator_degree  in  AW  degree of sigma, from the key-equation solver
code_len  in  8  n, legal range 2*NPAR+1..255; sampled at start
start  in  1  begin correction (1-cycle pulse)
busy  out  1  high from the cycle after accepted start until done
buf_rden  out  1  delay-buffer read enable
buf_rdaddr  out  8  delay-buffer address
buf_q  in  8  buffer data, valid 1 cycle after buf_rden; holds while rden low
out_valid  out  1  corrected symbol valid
out_ready  in  1  downstream accept
out_data  out  8  corrected symbol
out_err  out  1  symbol was corrected
out_last  out  1  final symbol of codeword
done  out  1  1-cycle pulse after last symbol accepted
decoder_fail  out  1  valid at done; held until next start
error_count  out  AW  roots found; held until next start

Behaviour:
- Reset (async, reset=0): all outputs 0, coefficient registers 0, state IDLE.
- IDLE:
  - coef_wr writes sigma[coef_addr] or omega[coef_addr]; addresses > NPAR ignored.
  - coef_wr while busy is ignored.
- start:
  - start in IDLE latches n = code_len; goes to PRECOMP.
  - start while busy is ignored.
  - code_len outside the legal range: no run; done pulses next cycle with decoder_fail=1.
- Position mapping:
  - Buffer address a (0..n-1) holds the symbol of degree j = n-1-a.
  - Evaluation point x_a = alpha^(-j) = alpha^((a+256-n) mod 255).
- PRECOMP, NPAR+1 cycles:
  - s = alpha^((256-n) mod 255), obtained by internal exp-table function.
  - Coefficient k scaled by s^k using a running power, one k per cycle: sigma_k and omega_k both multiplied.
  - xb register initialised to s^FCR.
- RUN, one position per advancing cycle:
  - Chien register k is multiplied by alpha^k each advance, with separate banks for sigma and omega.
  - Stage 0: buf_rden=1, buf_rdaddr=a; register sigma(x_a), sigma_odd(x_a) (odd-index sum) and omega(x_a).
  - Stage 1: buf_q arrives. If sigma(x_a)=0 the position is an error, e = xb * omega * inv(sigma_odd), with inv from an internal log/antilog function. Registers out_data = buf_q ^ e when an error, else buf_q; out_err mirrors the error decision.
  - Latency: address issue to out_valid is 2 cycles.
  - xb is multiplied by alpha^FCR each advance.
  - out_last=1 with a=n-1.
- Stall:
  - When out_valid=1 and out_ready=0, all stages, Chien registers and address freeze; buf_rden=0.
  - out_data, out_err and out_last are held.
- Error counting:
  - error_count increments (saturating at 2^AW-1) on each sigma root, counted when its symbol is accepted.
  - A root whose sigma_odd=0 sets a sticky fail bit; that symbol passes uncorrected.
- DONE:
  - Entered when the out_last beat is accepted.
  - done pulses 1 cycle; busy drops the same cycle.
  - decoder_fail = sticky fail OR (error_count != locator_degree).
  - Returns to IDLE; sigma/omega are cleared to 0.
- locator_degree=0: no roots are expected; the data passes through unchanged with fail=0 if none are found.
- Reset mid-run aborts immediately: no done pulse.

Test Plan:
- Error-free codeword, NPAR=16, n=255, sigma=1, omega=0, locator_degree=0 -> 255 beats, out_data==buf_q, out_err=0, error_count=0, decoder_fail=0, first out_valid 2 cycles after first buf_rden.
- Single error at address 10 (value 0x5A), n=255, sigma/omega from the reference model -> only beat 10 has out_err=1 and corrected symbol; error_count=1; fail=0.
- Shortened n=64 with 8 errors at random addresses -> all corrected; 64 beats; out_last on beat 63; done 1 cycle after last accept.
- Backpressure: out_ready toggled randomly at 50% during the single-error case -> identical output sequence; buf_rdaddr frozen while stalled; no beat duplicated or dropped.
- locator_degree=3 but sigma has only 2 roots in range -> error_count=2, decoder_fail=1.
- reset=0 asserted mid-RUN, then a fresh load and start -> no done pulse from the aborted run; second run matches the model; coef_wr and start ignored while busy.
